imm_gen_queue: RTL and testbench

IMM_GEN_QUEUE -- requirements
Module: imm_gen_queue

---
 rtl/imm_gen_queue_if.sv | 27 ++
 rtl/imm_gen_queue.sv | 94 +++++++++
 tb/tb_imm_gen_queue.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/imm_gen_queue_if.sv
// Handshake bundle between the decode producer/consumer and imm_gen_queue.
// The master side drives instructions and accepts immediates.
interface imm_gen_queue_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
);
  logic                     flush;
  logic                     in_valid;
  logic                     in_ready;
  logic [31:0]              instr;
  logic [2:0]               imm_src;
  logic                     out_valid;
  logic                     out_ready;
  logic [XLEN-1:0]          imm_ext;
  logic                     imm_err;
  logic [$clog2(DEPTH):0]   count;

  modport master (
    output flush, in_valid, instr, imm_src, out_ready,
    input  in_ready, out_valid, imm_ext, imm_err, count
  );

  modport slave (
    input  flush, in_valid, instr, imm_src, out_ready,
    output in_ready, out_valid, imm_ext, imm_err, count
  );
endinterface

// File: rtl/imm_gen_queue.sv
// RISC-V immediate generator feeding a small FIFO; immediates are decoded at
// enqueue time so the output side is purely registered storage.
module imm_gen_queue #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input logic           clk,
  input logic           rst_n,
  imm_gen_queue_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [XLEN-1:0] imm_mem [DEPTH];
  logic            err_mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   occupancy;

  logic            ready;
  logic            valid;
  logic            do_enq;
  logic            do_deq;
  logic [31:0]     imm32;
  logic            new_err;
  logic [XLEN-1:0] new_imm;
  logic            unused_opcode;

  assign ready  = (occupancy != FULL);
  assign valid  = (occupancy != '0);
  assign do_enq = bus.in_valid && ready && !bus.flush;
  assign do_deq = valid && bus.out_ready && !bus.flush;

  // The opcode field carries no immediate bits in any format.
  assign unused_opcode = ^bus.instr[6:0];

  always_comb begin
    imm32   = '0;
    new_err = 1'b0;
    case (bus.imm_src)
      3'd0: imm32 = {{20{bus.instr[31]}}, bus.instr[31:20]};
      3'd1: imm32 = {{20{bus.instr[31]}}, bus.instr[31:25], bus.instr[11:7]};
      3'd2: imm32 = {{19{bus.instr[31]}}, bus.instr[31], bus.instr[7],
                     bus.instr[30:25], bus.instr[11:8], 1'b0};
      3'd3: imm32 = {bus.instr[31:12], 12'b0};
      3'd4: imm32 = {{11{bus.instr[31]}}, bus.instr[31], bus.instr[19:12],
                     bus.instr[20], bus.instr[30:21], 1'b0};
      3'd5: imm32 = {27'b0, bus.instr[19:15]};
      default: begin
        imm32   = '0;
        new_err = 1'b1;
      end
    endcase
  end

  // Every format fits in 32 bits with bit 31 as sign (zimm has bit 31 clear),
  // so a single signed widening covers both XLEN choices.
  assign new_imm = XLEN'($signed(imm32));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else if (bus.flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else begin
      if (do_enq) wr_ptr <= wr_ptr + 1'b1;
      if (do_deq) rd_ptr <= rd_ptr + 1'b1;
      case ({do_enq, do_deq})
        2'b10:   occupancy <= occupancy + 1'b1;
        2'b01:   occupancy <= occupancy - 1'b1;
        default: occupancy <= occupancy;
      endcase
    end
  end

  // Storage is not reset; stale slots are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (do_enq) begin
      imm_mem[wr_ptr] <= new_imm;
      err_mem[wr_ptr] <= new_err;
    end
  end

  assign bus.in_ready  = ready;
  assign bus.out_valid = valid;
  assign bus.count     = occupancy;
  assign bus.imm_ext   = valid ? imm_mem[rd_ptr] : '0;
  assign bus.imm_err   = valid ? err_mem[rd_ptr] : 1'b0;
endmodule

// File: tb/tb_imm_gen_queue.sv
// Directed and scoreboarded checks of imm_gen_queue at XLEN=32 and XLEN=64,
// both instances with DEPTH=2.
module tb_imm_gen_queue;
  logic clk;
  logic rst_n;
  int   vector_count;
  int   miss_count;

  imm_gen_queue_if #(.XLEN(32), .DEPTH(2)) b32 ();
  imm_gen_queue_if #(.XLEN(64), .DEPTH(2)) b64 ();

  imm_gen_queue #(.XLEN(32), .DEPTH(2)) u32 (.clk(clk), .rst_n(rst_n), .bus(b32.slave));
  imm_gen_queue #(.XLEN(64), .DEPTH(2)) u64 (.clk(clk), .rst_n(rst_n), .bus(b64.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vector_count++;
    if (got !== exp) begin
      miss_count++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drives one bus for the coming edge (the other idles), then steps past it.
  task automatic applyStimulus(input bit sel64, input logic v, input logic [31:0] ins,
                               input logic [2:0] src, input logic ordy, input logic fl);
    b32.in_valid  = sel64 ? 1'b0 : v;
    b32.instr     = ins;
    b32.imm_src   = src;
    b32.out_ready = sel64 ? 1'b0 : ordy;
    b32.flush     = sel64 ? 1'b0 : fl;
    b64.in_valid  = sel64 ? v : 1'b0;
    b64.instr     = ins;
    b64.imm_src   = src;
    b64.out_ready = sel64 ? ordy : 1'b0;
    b64.flush     = sel64 ? fl : 1'b0;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] refImm(input logic [31:0] i, input logic [2:0] s);
    case (s)
      3'd0: return {{20{i[31]}}, i[31:20]};
      3'd1: return {{20{i[31]}}, i[31:25], i[11:7]};
      3'd2: return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      3'd3: return {i[31:12], 12'b0};
      3'd4: return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      3'd5: return {27'b0, i[19:15]};
      default: return 32'b0;
    endcase
  endfunction

  logic [32:0] model_q[$];

  initial begin
    vector_count = 0;
    miss_count   = 0;
    rst_n = 1'b0;
    applyStimulus(0, 0, 32'h0, 3'd0, 0, 0);
    applyStimulus(0, 0, 32'h0, 3'd0, 0, 0);
    rst_n = 1'b1;
    checkOutput("rst_count",     64'(b32.count),     64'd0);
    checkOutput("rst_out_valid", 64'(b32.out_valid), 64'd0);
    checkOutput("rst_in_ready",  64'(b32.in_ready),  64'd1);
    checkOutput("rst_imm_ext",   64'(b32.imm_ext),   64'd0);
    checkOutput("rst_imm_err",   64'(b32.imm_err),   64'd0);
    checkOutput("rst_count64",   64'(b64.count),     64'd0);

    // Streaming four formats at XLEN=32, one result per cycle.
    applyStimulus(0, 1, 32'hFFF00093, 3'd0, 1, 0);
    checkOutput("i_valid", 64'(b32.out_valid), 64'd1);
    checkOutput("i_imm",   64'(b32.imm_ext),   64'hFFFFFFFF);
    applyStimulus(0, 1, 32'h0020A423, 3'd1, 1, 0);
    checkOutput("s_imm",   64'(b32.imm_ext),   64'h00000008);
    applyStimulus(0, 1, 32'hFE000EE3, 3'd2, 1, 0);
    checkOutput("b_imm",   64'(b32.imm_ext),   64'hFFFFFFFC);
    applyStimulus(0, 1, 32'h0010006F, 3'd4, 1, 0);
    checkOutput("j_imm",   64'(b32.imm_ext),   64'h00000800);
    checkOutput("j_count", 64'(b32.count),     64'd1);
    applyStimulus(0, 0, 32'h0, 3'd0, 1, 0);
    checkOutput("drain_valid", 64'(b32.out_valid), 64'd0);

    // XLEN=64 sign and zero extension.
    applyStimulus(1, 1, 32'h123450B7, 3'd3, 1, 0);
    checkOutput("u64_pos", b64.imm_ext, 64'h0000000012345000);
    applyStimulus(1, 1, 32'h80000037, 3'd3, 1, 0);
    checkOutput("u64_neg", b64.imm_ext, 64'hFFFFFFFF80000000);
    applyStimulus(1, 1, 32'h00FF8073, 3'd5, 1, 0);
    checkOutput("z64",     b64.imm_ext, 64'h000000000000001F);
    checkOutput("z64_err", 64'(b64.imm_err), 64'd0);
    applyStimulus(1, 0, 32'h0, 3'd0, 1, 0);
    checkOutput("drain64", 64'(b64.out_valid), 64'd0);

    // Backpressure: full queue refuses a third entry until a slot frees.
    applyStimulus(0, 1, 32'h00100093, 3'd0, 0, 0);
    checkOutput("bp_count1", 64'(b32.count),    64'd1);
    checkOutput("bp_ready1", 64'(b32.in_ready), 64'd1);
    applyStimulus(0, 1, 32'h00200093, 3'd0, 0, 0);
    checkOutput("bp_count2", 64'(b32.count),    64'd2);
    checkOutput("bp_ready2", 64'(b32.in_ready), 64'd0);
    applyStimulus(0, 1, 32'h00300093, 3'd0, 0, 0);
    checkOutput("bp_hold_count", 64'(b32.count),   64'd2);
    checkOutput("bp_hold_imm",   64'(b32.imm_ext), 64'd1);
    applyStimulus(0, 1, 32'h00300093, 3'd0, 1, 0);
    checkOutput("bp_nobypass_count", 64'(b32.count),   64'd1);
    checkOutput("bp_second",         64'(b32.imm_ext), 64'd2);
    applyStimulus(0, 1, 32'h00300093, 3'd0, 1, 0);
    checkOutput("bp_simul_count", 64'(b32.count),   64'd1);
    checkOutput("bp_third",       64'(b32.imm_ext), 64'd3);
    applyStimulus(0, 0, 32'h0, 3'd0, 1, 0);
    checkOutput("bp_empty_valid", 64'(b32.out_valid), 64'd0);
    checkOutput("bp_empty_imm",   64'(b32.imm_ext),   64'd0);

    // Flush beats a same-cycle enqueue.
    applyStimulus(0, 1, 32'h00500093, 3'd0, 0, 0);
    checkOutput("fl_pre_count", 64'(b32.count), 64'd1);
    applyStimulus(0, 1, 32'h00700093, 3'd0, 0, 1);
    checkOutput("fl_count", 64'(b32.count),     64'd0);
    checkOutput("fl_valid", 64'(b32.out_valid), 64'd0);
    applyStimulus(0, 0, 32'h0, 3'd0, 0, 0);
    checkOutput("fl_dropped", 64'(b32.count), 64'd0);

    // Illegal format followed by a legal one.
    applyStimulus(0, 1, 32'hFFFFFFFF, 3'd6, 0, 0);
    checkOutput("ill_imm", 64'(b32.imm_ext), 64'd0);
    checkOutput("ill_err", 64'(b32.imm_err), 64'd1);
    applyStimulus(0, 1, 32'hFFF00093, 3'd0, 1, 0);
    checkOutput("post_ill_err", 64'(b32.imm_err), 64'd0);
    checkOutput("post_ill_imm", 64'(b32.imm_ext), 64'hFFFFFFFF);
    applyStimulus(0, 0, 32'h0, 3'd0, 1, 0);

    // Reset mid-stream discards queued entries and wins over a handshake.
    applyStimulus(0, 1, 32'h00900093, 3'd0, 0, 0);
    applyStimulus(0, 1, 32'h00A00093, 3'd0, 0, 0);
    checkOutput("rf_full", 64'(b32.count), 64'd2);
    rst_n = 1'b0;
    applyStimulus(0, 1, 32'h00B00093, 3'd0, 1, 1);
    rst_n = 1'b1;
    checkOutput("rf_count", 64'(b32.count),     64'd0);
    checkOutput("rf_valid", 64'(b32.out_valid), 64'd0);
    checkOutput("rf_ready", 64'(b32.in_ready),  64'd1);
    applyStimulus(0, 0, 32'h0, 3'd0, 1, 0);
    checkOutput("rf_no_stale", 64'(b32.out_valid), 64'd0);

    // Random traffic across pointer wrap against a reference queue.
    model_q.delete();
    for (int cyc = 0; cyc < 20; cyc++) begin
      logic        v, ordy, enq, deq;
      logic [31:0] ins;
      logic [2:0]  src;
      v    = 1'($urandom_range(0, 1));
      ordy = 1'($urandom_range(0, 1));
      ins  = $urandom();
      src  = 3'($urandom_range(0, 7));
      checkOutput("sb_count", 64'(b32.count),     64'(model_q.size()));
      checkOutput("sb_valid", 64'(b32.out_valid), 64'(model_q.size() != 0));
      if (model_q.size() != 0) begin
        checkOutput("sb_imm", 64'(b32.imm_ext), 64'(model_q[0][31:0]));
        checkOutput("sb_err", 64'(b32.imm_err), 64'(model_q[0][32]));
      end
      enq = v && (model_q.size() < 2);
      deq = ordy && (model_q.size() > 0);
      if (deq) void'(model_q.pop_front());
      if (enq) model_q.push_back({(src > 3'd5), refImm(ins, src)});
      applyStimulus(0, v, ins, src, ordy, 0);
    end
    checkOutput("sb_final_count", 64'(b32.count), 64'(model_q.size()));

    $display("== %0d vectors applied, %0d miscompares ==", vector_count, miss_count);
    $finish;
  end
endmodule
